// File: rtl/serv_dbus_if_pkg.sv
// Shared types and constants for the SERV data-bus Wishbone adapter.
//   state_e      : adapter FSM states
//   SZ_*         : access size codes as presented by the core (11 behaves as word)
//   CNT_W        : width of the bus timeout counter
//   is_aligned() : natural-alignment test for a size / address-LSB pair
package serv_dbus_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 8;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lsb[0];
      default: return (lsb == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/serv_dbus_lane.sv
// Byte-lane steering for stores: purely combinational.
//   i_size    : access size code
//   i_adr_lsb : address bits [1:0]
//   i_wdat    : LSB-aligned store data
//   o_sel     : Wishbone byte enables
//   o_dat     : store data replicated across all lanes it may land on
module serv_dbus_lane
  import serv_dbus_if_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_adr_lsb,
  input  logic [31:0] i_wdat,
  output logic [3:0]  o_sel,
  output logic [31:0] o_dat
);

  always_comb begin
    o_sel = 4'b1111;
    o_dat = i_wdat;
    case (i_size)
      SZ_BYTE: begin
        o_sel = 4'b0001 << i_adr_lsb;
        o_dat = {4{i_wdat[7:0]}};
      end
      SZ_HALF: begin
        o_sel = 4'b0011 << {i_adr_lsb[1], 1'b0};
        o_dat = {2{i_wdat[15:0]}};
      end
      default: begin
        o_sel = 4'b1111;
        o_dat = i_wdat;
      end
    endcase
  end

endmodule

// File: rtl/serv_dbus_if.sv
// SERV data-bus to Wishbone adapter with misalignment rejection and bus timeout.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_req/i_we/i_size/i_adr/i_wdat : core access request, sampled in IDLE only
//   i_wb_ack, i_wb_rdt      : Wishbone response
//   o_wb_adr/dat/sel/we/cyc : Wishbone request, held stable through BUS
//   o_rdat, o_load          : registered load word and its one-cycle valid
//   o_ack                   : one-cycle completion pulse (loads and stores)
//   o_misalign, o_err       : one-cycle rejection / timeout pulses
//   o_busy                  : FSM not in IDLE
// TIMEOUT = number of BUS cycles allowed without ack; 0 disables the timeout.
module serv_dbus_if
  import serv_dbus_if_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdat,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_rdt,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic [31:0] o_rdat,
  output logic        o_load,
  output logic        o_ack,
  output logic        o_misalign,
  output logic        o_err,
  output logic        o_busy
);

  // Timeout fires on the TIMEOUT-th BUS cycle, i.e. when the count of
  // already-elapsed unacked cycles equals TIMEOUT-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_capture;
  logic              w_misalign;
  logic              w_timeout;
  logic              w_to_hit;
  logic [3:0]        w_sel;
  logic [31:0]       w_dat;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_adr;
  logic [31:0]       r_dat;
  logic [3:0]        r_sel;
  logic              r_we;
  logic [31:0]       r_rdat;
  logic              r_misalign;
  logic              r_err;

  serv_dbus_lane u_lane (
    .i_size    (i_size),
    .i_adr_lsb (i_adr[1:0]),
    .i_wdat    (i_wdat),
    .o_sel     (w_sel),
    .o_dat     (w_dat)
  );

  assign w_to_hit = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_misalign  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          if (is_aligned(i_size, i_adr[1:0])) begin
            w_state_nxt = ST_BUS;
            w_capture   = 1'b1;
          end else begin
            w_misalign  = 1'b1;
          end
        end
      end
      ST_BUS: begin
        // ack has priority over a coincident timeout
        if (i_wb_ack) begin
          w_state_nxt = ST_DONE;
        end else if (w_to_hit) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_adr      <= '0;
      r_dat      <= '0;
      r_sel      <= '0;
      r_we       <= 1'b0;
      r_rdat     <= '0;
      r_cnt      <= '0;
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_misalign <= w_misalign;
      r_err      <= w_timeout;
      if (w_capture) begin
        r_adr <= {i_adr[31:2], 2'b00};
        r_dat <= w_dat;
        r_sel <= w_sel;
        r_we  <= i_we;
        r_cnt <= '0;
      end else if (r_state == ST_BUS && !i_wb_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == ST_BUS && i_wb_ack && !r_we) r_rdat <= i_wb_rdt;
    end
  end

  assign o_wb_adr   = r_adr;
  assign o_wb_dat   = r_dat;
  assign o_wb_sel   = r_sel;
  assign o_wb_cyc   = (r_state == ST_BUS);
  assign o_wb_we    = (r_state == ST_BUS) && r_we;
  assign o_rdat     = r_rdat;
  assign o_ack      = (r_state == ST_DONE);
  assign o_load     = (r_state == ST_DONE) && !r_we;
  assign o_misalign = r_misalign;
  assign o_err      = r_err;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serv_dbus_if.sv
module tb_serv_dbus_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, ack;
  logic [1:0]  size;
  logic [31:0] adr, wdat, rdt;

  logic [31:0] wb_adr, wb_dat, rdat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, load, oack, misalign, err, busy;

  logic [31:0] w3_adr, w3_dat, r3dat;
  logic [3:0]  w3_sel;
  logic        w3_we, w3_cyc, l3, a3, m3, e3, b3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serv_dbus_if #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
    .i_adr(adr), .i_wdat(wdat), .i_wb_ack(ack), .i_wb_rdt(rdt),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
    .o_wb_cyc(wb_cyc), .o_rdat(rdat), .o_load(load), .o_ack(oack),
    .o_misalign(misalign), .o_err(err), .o_busy(busy)
  );

  serv_dbus_if #(.TIMEOUT(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
    .i_adr(adr), .i_wdat(wdat), .i_wb_ack(ack), .i_wb_rdt(rdt),
    .o_wb_adr(w3_adr), .o_wb_dat(w3_dat), .o_wb_sel(w3_sel), .o_wb_we(w3_we),
    .o_wb_cyc(w3_cyc), .o_rdat(r3dat), .o_load(l3), .o_ack(a3),
    .o_misalign(m3), .o_err(e3), .o_busy(b3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = s; adr = a; wdat = d;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({wb_cyc, wb_we, load, oack, misalign, err, busy} !== 7'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000000", {wb_cyc, wb_we, load, oack, misalign, err, busy}); end
    total++; if ({wb_adr, wb_dat, rdat} !== 96'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {wb_adr, wb_dat, rdat}); end
    total++; if (wb_sel !== 4'h0) begin bad++; $display("FAIL reset_sel got=%b exp=0000", wb_sel); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_byte();
    issue(1'b1, 2'b00, 32'h0000_1003, 32'h0000_00A5);
    @(negedge clk);
    total++; if ({wb_cyc, wb_we, busy} !== 3'b111) begin bad++; $display("FAIL sb_cyc_we_busy got=%b exp=111", {wb_cyc, wb_we, busy}); end
    total++; if (wb_sel !== 4'b1000) begin bad++; $display("FAIL sb_sel got=%b exp=1000", wb_sel); end
    total++; if (wb_dat !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_dat got=%h exp=a5a5a5a5", wb_dat); end
    total++; if (wb_adr !== 32'h0000_1000) begin bad++; $display("FAIL sb_adr got=%h exp=00001000", wb_adr); end
    tick();
    ack = 1'b1;
    @(negedge clk);
    total++; if ({wb_cyc, oack} !== 2'b10) begin bad++; $display("FAIL sb_cycle2 got=%b exp=10", {wb_cyc, oack}); end
    tick();
    ack = 1'b0;
    @(negedge clk);
    total++; if ({oack, load, wb_cyc, wb_we} !== 4'b1000) begin bad++; $display("FAIL sb_done got=%b exp=1000", {oack, load, wb_cyc, wb_we}); end
    tick();
    @(negedge clk);
    total++; if ({oack, busy} !== 2'b00) begin bad++; $display("FAIL sb_idle got=%b exp=00", {oack, busy}); end
    tick();
  endtask

  task automatic test_load_word();
    issue(1'b0, 2'b10, 32'h0000_2000, 32'h0);
    ack = 1'b1; rdt = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if ({wb_cyc, wb_we, wb_sel} !== 6'b10_1111) begin bad++; $display("FAIL lw_bus got=%b exp=101111", {wb_cyc, wb_we, wb_sel}); end
    tick();
    ack = 1'b0; rdt = 32'h0;
    @(negedge clk);
    total++; if ({oack, load} !== 2'b11) begin bad++; $display("FAIL lw_done got=%b exp=11", {oack, load}); end
    total++; if (rdat !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_rdat got=%h exp=deadbeef", rdat); end
    tick();
    @(negedge clk);
    total++; if ({oack, load} !== 2'b00) begin bad++; $display("FAIL lw_single got=%b exp=00", {oack, load}); end
    total++; if (rdat !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_hold got=%h exp=deadbeef", rdat); end
    tick();
  endtask

  task automatic test_lanes();
    logic [1:0]  vs [3] = '{2'b00, 2'b01, 2'b11};
    logic [31:0] va [3] = '{32'h0000_1001, 32'h0000_0002, 32'h0000_0010};
    logic [31:0] vd [3] = '{32'h1234_565A, 32'hFFFF_1234, 32'h8765_4321};
    logic [3:0]  es [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] ed [3] = '{32'h5A5A_5A5A, 32'h1234_1234, 32'h8765_4321};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, vs[i], va[i], vd[i]);
      ack = 1'b1;
      @(negedge clk);
      total++; if (wb_sel !== es[i]) begin bad++; $display("FAIL lane_sel[%0d] got=%b exp=%b", i, wb_sel, es[i]); end
      total++; if (wb_dat !== ed[i]) begin bad++; $display("FAIL lane_dat[%0d] got=%h exp=%h", i, wb_dat, ed[i]); end
      tick();
      ack = 1'b0;
      tick();
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  vs [2] = '{2'b01, 2'b10};
    logic [31:0] va [2] = '{32'h0000_0001, 32'h0000_0006};
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, vs[i], va[i], 32'h1111_2222);
      @(negedge clk);
      total++; if ({misalign, wb_cyc, busy, oack} !== 4'b1000) begin bad++; $display("FAIL misalign[%0d] got=%b exp=1000", i, {misalign, wb_cyc, busy, oack}); end
      tick();
      @(negedge clk);
      total++; if ({misalign, wb_cyc, busy, oack} !== 4'b0000) begin bad++; $display("FAIL misalign_after[%0d] got=%b exp=0000", i, {misalign, wb_cyc, busy, oack}); end
      tick();
    end
  endtask

  task automatic test_timeout();
    issue(1'b0, 2'b10, 32'h0000_3000, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++; if ({wb_cyc, err, oack} !== 3'b100) begin bad++; $display("FAIL to_bus[%0d] got=%b exp=100", c, {wb_cyc, err, oack}); end
      tick();
    end
    @(negedge clk);
    total++; if ({wb_cyc, err, oack, load, busy} !== 5'b01000) begin bad++; $display("FAIL to_err got=%b exp=01000", {wb_cyc, err, oack, load, busy}); end
    total++; if (rdat !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_rdat got=%h exp=deadbeef", rdat); end
    issue(1'b0, 2'b10, 32'h0000_4000, 32'h0);
    ack = 1'b1; rdt = 32'h0BAD_F00D;
    @(negedge clk);
    total++; if ({wb_cyc, err} !== 2'b10) begin bad++; $display("FAIL to_new_req got=%b exp=10", {wb_cyc, err}); end
    tick();
    ack = 1'b0; rdt = 32'h0;
    @(negedge clk);
    total++; if ({oack, load} !== 2'b11 || rdat !== 32'h0BAD_F00D) begin bad++; $display("FAIL to_new_done got=%b/%h exp=11/0badf00d", {oack, load}, rdat); end
    tick();
  endtask

  task automatic test_ack_timeout();
    issue(1'b1, 2'b10, 32'h0000_5000, 32'hCAFE_0001);
    tick();
    tick();
    ack = 1'b1;
    @(negedge clk);
    total++; if (w3_cyc !== 1'b1) begin bad++; $display("FAIL at_cycle3 got=%b exp=1", w3_cyc); end
    tick();
    ack = 1'b0;
    @(negedge clk);
    total++; if ({a3, e3, l3} !== 3'b100) begin bad++; $display("FAIL at_ack_wins got=%b exp=100", {a3, e3, l3}); end
    tick();
    @(negedge clk);
    total++; if ({a3, e3, b3} !== 3'b000) begin bad++; $display("FAIL at_after got=%b exp=000", {a3, e3, b3}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic ecyc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic eack [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    req = 1'b1; we = 1'b1; size = 2'b10; adr = 32'h0000_6000; wdat = 32'h0;
    tick();
    ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if ({wb_cyc, oack} !== {ecyc[c], eack[c]}) begin bad++; $display("FAIL b2b[%0d] got=%b exp=%b", c, {wb_cyc, oack}, {ecyc[c], eack[c]}); end
      tick();
    end
    req = 1'b0;
    tick();
    ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_bus();
    int acks = 0;
    issue(1'b0, 2'b10, 32'h0000_7000, 32'h0);
    @(negedge clk);
    total++; if (wb_cyc !== 1'b1) begin bad++; $display("FAIL rm_in_bus got=%b exp=1", wb_cyc); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({wb_cyc, wb_we, busy, oack} !== 4'b0000) begin bad++; $display("FAIL rm_async got=%b exp=0000", {wb_cyc, wb_we, busy, oack}); end
    total++; if ({rdat, wb_adr} !== 64'h0) begin bad++; $display("FAIL rm_clear got=%h exp=0", {rdat, wb_adr}); end
    tick();
    rst_n = 1'b1;
    ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (oack || wb_cyc) acks++;
      tick();
    end
    ack = 1'b0;
    total++; if (acks !== 0) begin bad++; $display("FAIL rm_no_ack got=%0d exp=0", acks); end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00;
    adr = 32'h0; wdat = 32'h0; ack = 1'b0; rdt = 32'h0;
    test_reset();
    test_store_byte();
    test_load_word();
    test_lanes();
    test_misalign();
    test_timeout();
    test_ack_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
